// File: rtl/uart_tx.sv
// FIFO-fed UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_rdreq,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int              IW        = $clog2(DATA_WIDTH) + 1;
    localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [IW-1:0]   DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0]   STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state, state_nxt;
    logic [15:0]           baud;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_sh;
    logic                  tick;

    assign tick       = (baud == BAUD_LAST);
    assign shreg_sh   = shreg >> bit_idx;
    assign fifo_rdreq = (state == READ);
    assign busy       = (state != IDLE);
    // bit_idx doubles as the stop-bit counter so two stop bits need no extra state
    assign tx_done    = (state == STOP) && tick && (bit_idx == STOP_LAST);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        txd       = 1'b1;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = READ;
            READ:  state_nxt = LOAD;
            LOAD:  state_nxt = START;
            START: begin
                txd = 1'b0;
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                txd = shreg_sh[0];
                if (tick && bit_idx == DATA_LAST)
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
            end
            PARITY: begin
                txd = ^shreg;
                if (tick) state_nxt = STOP;
`else
                    state_nxt = STOP;
`endif
            end
            STOP:  if (tick && bit_idx == STOP_LAST) state_nxt = fifo_empty ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_nxt != state || tick) baud <= '0;
            else                            baud <= baud + 16'd1;
            if (state_nxt != state) bit_idx <= '0;
            else if (tick)          bit_idx <= bit_idx + IW'(1);
            if (state == LOAD) shreg <= fifo_q;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (CLK_DIV=4/1 stop, CLK_DIV=2/2 stop) fed by queue FIFOs,
// traces compared against a bit-list frame model plus table-driven timing/parity/gap checks.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DIV_A = 4, STOP_A = 1, DIV_B = 2, STOP_B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clock = 1'b0;
    logic       aclr_n;
    logic       empty_a, empty_b;
    logic [7:0] q_a, q_b;
    logic       rdreq_a, txd_a, busy_a, done_a;
    logic       rdreq_b, txd_b, busy_b, done_b;

    always #5 clock = ~clock;

    uart_tx #(.CLK_DIV(DIV_A), .DATA_WIDTH(8), .STOP_BITS(STOP_A)) dut_a (
        .clock(clock), .aclr_n(aclr_n), .fifo_empty(empty_a), .fifo_q(q_a),
        .fifo_rdreq(rdreq_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a));

    uart_tx #(.CLK_DIV(DIV_B), .DATA_WIDTH(8), .STOP_BITS(STOP_B)) dut_b (
        .clock(clock), .aclr_n(aclr_n), .fifo_empty(empty_b), .fifo_q(q_b),
        .fifo_rdreq(rdreq_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b));

    typedef struct packed {logic txd; logic busy; logic rdreq; logic done;} obs_t;

    typedef struct {
        string      name;
        int         u;
        int         n;
        logic [7:0] b0, b1;
        int         done_off;
        int         rdq;
        int         par;
        int         gap;
        int         stop_hi;
    } vec_t;

    int         checks = 0, failures = 0;
    logic [7:0] fq_a[$], fq_b[$];
    logic [7:0] msg[$];
    obs_t       last;
    obs_t       act[$], expq[$];
    string      sig_n[4] = '{"tx_done", "fifo_rdreq", "busy", "txd"};
    int         m_rdreq, m_done_off, m_par, m_gap, m_stop_hi;
    vec_t       vt[6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One clock cycle: sample at the falling edge, then behave as a registered-read FIFO.
    task automatic step(input int u);
        logic pop;
        @(negedge clock);
        if (u == 0) last = {txd_a, busy_a, rdreq_a, done_a};
        else        last = {txd_b, busy_b, rdreq_b, done_b};
        pop = last.rdreq;
        @(posedge clock);
        #1;
        if (u == 0) begin
            if (pop && fq_a.size() > 0) q_a = fq_a.pop_front();
            empty_a = (fq_a.size() == 0);
        end else begin
            if (pop && fq_b.size() > 0) q_b = fq_b.pop_front();
            empty_b = (fq_b.size() == 0);
        end
    endtask

    // Reference: each frame is a list of line levels, each held div cycles, preceded by READ and LOAD.
    task automatic build_exp(input int div, input int nstop, input int tail);
        logic bits[$];
        expq.delete();
        expq.push_back(obs_t'(4'b1000));
        foreach (msg[k]) begin
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(msg[k][i]);
            if (PAR != 0) bits.push_back(^msg[k]);
            for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
            expq.push_back(obs_t'(4'b1110));
            expq.push_back(obs_t'(4'b1100));
            foreach (bits[j])
                for (int c = 0; c < div; c++)
                    expq.push_back('{txd: bits[j], busy: 1'b1, rdreq: 1'b0,
                                     done: (j == bits.size() - 1 && c == div - 1)});
        end
        repeat (tail) expq.push_back(obs_t'(4'b1000));
    endtask

    task automatic measure(input int div);
        int rd, dn, c;
        rd = -1; dn = -1;
        m_rdreq = 0; m_done_off = -1; m_par = -1; m_gap = -1; m_stop_hi = 0;
        foreach (act[i]) begin
            if (act[i].rdreq) begin m_rdreq++; if (rd < 0) rd = i; end
            if (act[i].done && dn < 0) dn = i;
        end
        if (rd >= 0 && dn > rd + 2 + 9 * div) begin
            m_done_off = dn - (rd + 1);
            m_par = int'(act[rd + 2 + 9 * div].txd);
            for (c = dn; c >= 0 && act[c].txd; c--) m_stop_hi++;
            for (c = dn + 1; c < act.size() && act[c].txd; c++) ;
            if (c < act.size()) m_gap = c - dn - 1;
        end
    endtask

    task automatic run(input int u, input string name);
        logic [3:0] a, e;
        int fm;
        build_exp(u == 0 ? DIV_A : DIV_B, u == 0 ? STOP_A : STOP_B, 6);
        foreach (msg[k]) begin
            if (u == 0) fq_a.push_back(msg[k]);
            else        fq_b.push_back(msg[k]);
        end
        if (u == 0) empty_a = 1'b0;
        else        empty_b = 1'b0;
        act.delete();
        for (int c = 0; c < expq.size(); c++) begin
            step(u);
            act.push_back(last);
        end
        for (int s = 0; s < 4; s++) begin
            fm = 0;
            for (int c = expq.size() - 1; c >= 0; c--) begin
                a = act[c]; e = expq[c];
                if (a[s] !== e[s]) fm = c;
            end
            a = act[fm]; e = expq[fm];
            check($sformatf("%s %s cycle %0d", name, sig_n[s], fm), 32'(a[s]), 32'(e[s]));
        end
        measure(u == 0 ? DIV_A : DIV_B);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt_busy, cnt_rd, cnt_low, found;
        vt[0] = '{"x55",      0, 1, 8'h55, 8'h00, 40 + 4 * PAR, 1, 0, -1, 4};
        vt[1] = '{"xA5_x3C",  0, 2, 8'hA5, 8'h3C, 40 + 4 * PAR, 2, 0,  2, -1};
        vt[2] = '{"x07",      0, 1, 8'h07, 8'h00, 40 + 4 * PAR, 1, 1, -1, -1};
        vt[3] = '{"x03",      0, 1, 8'h03, 8'h00, 40 + 4 * PAR, 1, 0, -1, 4};
        vt[4] = '{"b_x12",    1, 1, 8'h12, 8'h00, 22 + 2 * PAR, 1, 0, -1, 4};
        vt[5] = '{"b_xFF",    1, 1, 8'hFF, 8'h00, 22 + 2 * PAR, 1, 0, -1, -1};

        aclr_n = 1'b0; empty_a = 1'b1; empty_b = 1'b1; q_a = '0; q_b = '0;
        #12;
        check("reset txd_a",   32'(txd_a),   32'd1);
        check("reset busy_a",  32'(busy_a),  32'd0);
        check("reset rdreq_a", 32'(rdreq_a), 32'd0);
        check("reset done_a",  32'(done_a),  32'd0);
        check("reset txd_b",   32'(txd_b),   32'd1);
        check("reset busy_b",  32'(busy_b),  32'd0);
        #10 aclr_n = 1'b1;
        @(posedge clock); #1;

        // Empty FIFO: line stays idle and nothing is requested
        cnt_low = 0; cnt_busy = 0; cnt_rd = 0;
        for (int c = 0; c < 100; c++) begin
            step(0);
            if (!last.txd) cnt_low++;
            if (last.busy) cnt_busy++;
            if (last.rdreq) cnt_rd++;
        end
        check("idle txd low cycles", 32'(cnt_low), 32'd0);
        check("idle busy cycles", 32'(cnt_busy), 32'd0);
        check("idle rdreq cycles", 32'(cnt_rd), 32'd0);

        foreach (vt[i]) begin
            msg.delete();
            msg.push_back(vt[i].b0);
            if (vt[i].n > 1) msg.push_back(vt[i].b1);
            run(vt[i].u, vt[i].name);
            check({vt[i].name, " rdreq pulses"}, 32'(m_rdreq), 32'(vt[i].rdq));
            check({vt[i].name, " tx_done offset from LOAD"}, 32'(m_done_off), 32'(vt[i].done_off));
            check({vt[i].name, " level after data"}, 32'(m_par), 32'((PAR != 0) ? vt[i].par : 1));
            check({vt[i].name, " idle gap"}, 32'(m_gap), 32'(vt[i].gap));
            if (vt[i].stop_hi >= 0)
                check({vt[i].name, " stop high cycles"}, 32'(m_stop_hi), 32'(vt[i].stop_hi));
        end

        for (int r = 0; r < 8; r++) begin
            msg.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) msg.push_back(8'($urandom));
            run(r % 2, $sformatf("rand%0d", r));
            check($sformatf("rand%0d rdreq pulses", r), 32'(m_rdreq), 32'(n));
        end

        // Reset mid-frame during data bit 3 of 0xFF
        fq_a.push_back(8'hFF); empty_a = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step(0);
            if (last.rdreq) found = 1;
        end
        check("reset test rdreq seen", 32'(found), 32'd1);
        repeat (19) step(0);
        check("reset test busy before", 32'(busy_a), 32'd1);
        #2 aclr_n = 1'b0;
        #1;
        check("async reset txd", 32'(txd_a), 32'd1);
        check("async reset busy", 32'(busy_a), 32'd0);
        check("async reset rdreq", 32'(rdreq_a), 32'd0);
        repeat (2) @(posedge clock);
        #3 aclr_n = 1'b1;
        @(posedge clock); #1;
        cnt_busy = 0; cnt_rd = 0;
        for (int c = 0; c < 20; c++) begin
            step(0);
            if (last.busy) cnt_busy++;
            if (last.rdreq) cnt_rd++;
        end
        check("post reset busy cycles", 32'(cnt_busy), 32'd0);
        check("post reset rdreq cycles", 32'(cnt_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, data bits per frame and width of fifo_q.
REQ-003 SHALL provide parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-004 SHALL provide port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL provide port aclr_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL provide port fifo_empty, input, 1 bit: the upstream FIFO's empty flag.
REQ-007 SHALL provide port fifo_q, input, DATA_WIDTH bits: the upstream FIFO's registered read data, valid the cycle after an accepted rdreq.
REQ-008 SHALL provide port fifo_rdreq, output, 1 bit: read request to the upstream FIFO.
REQ-009 SHALL provide port txd, output, 1 bit: serial line, idle high.
REQ-010 SHALL provide port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL provide port tx_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-012 SHALL implement the states IDLE, READ, LOAD, START, DATA, PARITY, STOP.
REQ-013 IDLE: txd=1; if fifo_empty=0, the next state SHALL be READ, otherwise remain in IDLE.
REQ-014 READ SHALL last exactly 1 cycle with fifo_rdreq=1; fifo_rdreq SHALL be 0 in every other state.
REQ-015 LOAD SHALL last 1 cycle and capture fifo_q into the shift register; the next state SHALL be START.
REQ-016 START SHALL drive txd=0 for CLK_DIV cycles.
REQ-017 DATA SHALL drive DATA_WIDTH bits LSB first, each held for CLK_DIV cycles.
REQ-018 A 16-bit baud counter SHALL count 0..CLK_DIV-1; a bit advances when the count equals CLK_DIV-1, and the counter SHALL clear on every state change.
REQ-019 A bit index counter of width $clog2(DATA_WIDTH)+1 SHALL select the data bit and SHALL clear on entry to DATA.
REQ-020 After the last data bit, the next state SHALL be PARITY when parity is enabled (REQ-028), otherwise STOP.
REQ-021 STOP SHALL drive txd=1 for STOP_BITS*CLK_DIV cycles.
REQ-022 tx_done SHALL pulse high in the final cycle of STOP.
REQ-023 At the end of STOP, the next state SHALL be READ if fifo_empty=0, else IDLE.
  - Back-to-back frames are separated by exactly 2 idle-high cycles (READ and LOAD).
REQ-024 Changes on fifo_empty or fifo_q outside IDLE, LOAD and the end of STOP SHALL be ignored; a frame in progress is never aborted except by reset.

Reset
REQ-025 While aclr_n=0, the block SHALL be held in reset, asynchronously, regardless of clock:
  - state=IDLE, txd=1, busy=0, tx_done=0, fifo_rdreq=0;
  - baud counter, bit index and shift register cleared.
REQ-026 Reset asserted mid-frame SHALL force txd=1 immediately; the byte being sent is lost and the FIFO is not re-read.
REQ-027 After aclr_n rises, the block SHALL first act on the next rising clock edge.

Configuration
REQ-028 Macro UART_TX_PARITY_EN:
  - Defined: PARITY state is compiled in and drives even parity (XOR of the data bits) for CLK_DIV cycles between DATA and STOP.
  - Undefined: no PARITY state logic exists and DATA goes directly to STOP.

Verification
REQ-029 Bench SHALL cover, with CLK_DIV=4, STOP_BITS=1, no parity: 0x55 sent ->
  - txd pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles;
  - tx_done high in cycle 40 after LOAD;
  - exactly one fifo_rdreq pulse.
REQ-030 Bench SHALL cover: FIFO holding 0xA5 then 0x3C -> two frames separated by exactly 2 high cycles; 2 rdreq pulses total.
REQ-031 Bench SHALL cover, with UART_TX_PARITY_EN defined: 0x07 sent -> parity bit 1; 0x03 sent -> parity bit 0; frame length 11 bits.
REQ-032 Bench SHALL cover: aclr_n pulled low during bit 3 of 0xFF ->
  - txd=1 and busy=0 without a clock edge;
  - after release with fifo_empty=1, the block stays in IDLE with no rdreq.
REQ-033 Bench SHALL cover, with STOP_BITS=2 and CLK_DIV=2: stop period is 4 high cycles and tx_done pulses on the 4th.
REQ-034 Bench SHALL cover: fifo_empty held at 1 -> txd remains 1, busy=0, fifo_rdreq never asserted for 100 cycles.
